sram_wb_ctrl: RTL and testbench

- Wishbone B4 classic slave (32-bit) that initiates accesses on the single-port 64-bit×512 OpenRAM macro port (clk0/csb0/web0/wmask0/addr0/din0/dout0).
- Sits between the Caravel user-project Wishbone bus and the macro.
- Maps a 4 KiB byte window onto the macro, steers 32-bit lanes into 64-bit words with byte masks, and times the macro's posedge-capture / negedge-access cycle.

---
 rtl/sram_wb_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_wb_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_ctrl.sv
// rtl/sram_wb_ctrl.sv - Wishbone B4 classic slave driving a 64x512 OpenRAM single-port macro
//
// Maps a 4 KiB byte window onto the macro. Each 32-bit access is steered
// into one lane of a 64-bit macro word with a byte write mask. Every access
// follows the same sequence of clock edges:
//   edge N   : request accepted, macro inputs loaded        (IDLE/RESP -> ISSUE)
//   edge N+1 : macro captures its inputs, chip select drops (ISSUE -> WAIT)
//   edge N+2 : read data sampled, ack raised                (WAIT -> RESP)
//   edge N+3 : ack cleared, next request may be accepted    (RESP -> IDLE/ISSUE)
//
// Build option: define SRAM_CTRL_ERR_EN to answer accesses outside the
// window with a one-cycle wbs_err_o pulse and no macro cycle. Without it,
// wbs_err_o stays 0 and the window aliases across the whole address space.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     clock (also the macro clk0) and async active-low reset
//   wbs_cyc_i, wbs_stb_i     bus cycle and strobe
//   wbs_we_i, wbs_sel_i      write enable and byte selects
//   wbs_adr_i, wbs_dat_i     byte address and write data
//   wbs_ack_o, wbs_err_o     acknowledge and error (never high together)
//   wbs_dat_o                read data, holds the last read value
//   sram_csb0, sram_web0     macro chip select and write enable, active low
//   sram_wmask0              macro byte write mask
//   sram_addr0, sram_din0    macro word address and write data
//   sram_dout0               macro read data
module sram_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SRAM_AW   = 9
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic [31:0]        wbs_dat_o,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [7:0]         sram_wmask0,
  output logic [SRAM_AW-1:0] sram_addr0,
  output logic [63:0]        sram_din0,
  input  logic [63:0]        sram_dout0
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0] state;
  logic       lane;
  logic       we_q;
  logic       req;
  logic       hit;
  logic [7:0] wmask_next;

  assign req = wbs_cyc_i & wbs_stb_i;

`ifdef SRAM_CTRL_ERR_EN
  assign hit = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[1:0], BASE_ADDR[11:0]};
`else
  // Upper address bits are ignored: every request lands in the window.
  assign hit = 1'b1;
  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[31:SRAM_AW+3], wbs_adr_i[1:0], BASE_ADDR};
`endif

  // Address bit 2 selects the upper or lower 32-bit half of the macro word.
  always_comb begin
    wmask_next = 8'h00;
    if (wbs_we_i) begin
      wmask_next = wbs_adr_i[2] ? {wbs_sel_i, 4'b0000} : {4'b0000, wbs_sel_i};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= ST_IDLE;
      lane        <= 1'b0;
      we_q        <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= 8'h00;
      sram_addr0  <= '0;
      sram_din0   <= 64'h0;
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= 32'h0;
    end else begin
      case (state)
        // RESP behaves like IDLE apart from retiring the response, so a
        // strobe held into edge N+3 starts the next access without a gap.
        ST_IDLE, ST_RESP: begin
          wbs_ack_o <= 1'b0;
          wbs_err_o <= 1'b0;
          state     <= ST_IDLE;
          if (req && hit) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~wbs_we_i;
            sram_wmask0 <= wmask_next;
            sram_addr0  <= wbs_adr_i[SRAM_AW+2:3];
            sram_din0   <= {wbs_dat_i, wbs_dat_i};
            lane        <= wbs_adr_i[2];
            we_q        <= wbs_we_i;
            state       <= ST_ISSUE;
          end else if (req) begin
            // Out-of-window request: no macro cycle, error pulse only.
            wbs_err_o <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_ISSUE: begin
          // The macro has captured its inputs on this edge; release it so
          // it never sees a second cycle. addr0/din0 are left as they are.
          sram_csb0   <= 1'b1;
          sram_web0   <= 1'b1;
          sram_wmask0 <= 8'h00;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // The macro accessed its array at the negedge just gone.
          if (!we_q) begin
            wbs_dat_o <= lane ? sram_dout0[63:32] : sram_dout0[31:0];
          end
          // An abandoned cycle still completes in the macro but is not acked.
          wbs_ack_o <= wbs_cyc_i;
          state     <= ST_RESP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// tb/tb_sram_wb_ctrl.sv - scoreboard testbench for sram_wb_ctrl with a behavioural OpenRAM model
module tb_sram_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack, err;
  logic [31:0] dat_r;
  logic        csb, web;
  logic [7:0]  wmask;
  logic [8:0]  addr0;
  logic [63:0] din0;
  logic [63:0] dout0 = 64'h0;

  int checks = 0;
  int errors = 0;
  int ack_wide = 0;
  int csb_overlap = 0;
  int err_seen = 0;
  logic prev_ack = 1'b0;
  logic prev_csb_low = 1'b0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  sram_wb_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_ack_o  (ack),
    .wbs_err_o  (err),
    .wbs_dat_o  (dat_r),
    .sram_csb0  (csb),
    .sram_web0  (web),
    .sram_wmask0(wmask),
    .sram_addr0 (addr0),
    .sram_din0  (din0),
    .sram_dout0 (dout0)
  );

  // Behavioural macro: captures on posedge, accesses on the following negedge.
  logic [63:0] mem [0:511];
  logic        m_csb = 1'b1;
  logic        m_web = 1'b1;
  logic [7:0]  m_wmask = 8'h0;
  logic [8:0]  m_addr = 9'h0;
  logic [63:0] m_din = 64'h0;

  always @(posedge clk) begin
    m_csb   <= csb;
    m_web   <= web;
    m_wmask <= wmask;
    m_addr  <= addr0;
    m_din   <= din0;
  end

  always @(negedge clk) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < 8; b++) begin
          if (m_wmask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
        end
      end else begin
        dout0 <= mem[m_addr];
      end
    end
  end

  // Protocol monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (ack && prev_ack) ack_wide++;
    if (!csb && prev_csb_low) csb_overlap++;
    if (err) err_seen++;
    prev_ack = ack;
    prev_csb_low = !csb;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  // Starts and ends at a negedge; leaves the strobe up so a following call
  // is sampled at edge N+3.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int cnt;
    logic [7:0] em;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      exp_q.push_back(ref_mem[a[11:2]]);
    end
    em = w ? (a[2] ? {s, 4'h0} : {4'h0, s}) : 8'h00;
    @(posedge clk); @(negedge clk);
    chk("csb_issue", csb, 1'b0);
    chk("web_issue", web, !w);
    chk("wmask_issue", wmask, em);
    chk("addr_issue", addr0, a[11:3]);
    cnt = 1;
    while (!ack && cnt < 10) begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    chk("ack_latency", cnt, 3);
    if (w) begin
      chk("dat_hold", dat_r, last_rd);
    end else if (exp_q.size() > 0) begin
      last_rd = exp_q.pop_front();
      chk("rdata", dat_r, last_rd);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
    rst_n = 1'b0;
    idle();
    sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", csb, 1'b1);
    chk("rst_web", web, 1'b1);
    chk("rst_wmask", wmask, 8'h00);
    chk("rst_addr", addr0, 9'h0);
    chk("rst_din", din0, 64'h0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dat", dat_r, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted while the macro cycle is being issued.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0F00; sel = 4'hF; dat_w = 32'h5555_AAAA;
    @(posedge clk); @(negedge clk);
    chk("mid_csb_low", csb, 1'b0);
    rst_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_csb", csb, 1'b1);
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_wmask", wmask, 8'h00);
    chk("mid_rst_din", din0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word writes to both lanes of word 1, then read back.
    access(1'b1, 32'h3000_0008, 4'hF, 32'hDEAD_BEEF);
    access(1'b1, 32'h3000_000C, 4'hF, 32'h1234_5678);
    access(1'b0, 32'h3000_0008, 4'hF, 32'h0);
    chk("rd_lo_const", dat_r, 32'hDEAD_BEEF);
    access(1'b0, 32'h3000_000C, 4'hF, 32'h0);
    chk("rd_hi_const", dat_r, 32'h1234_5678);
    idle();
    @(negedge clk);

    // Byte-masked write over existing data.
    access(1'b1, 32'h3000_0010, 4'hF, 32'h1122_3344);
    access(1'b1, 32'h3000_0010, 4'b0101, 32'hAABB_CCDD);
    access(1'b0, 32'h3000_0010, 4'hF, 32'h0);
    chk("bytemask_const", dat_r, 32'h11BB_33DD);
    idle();
    @(negedge clk);

    // Back-to-back alternating writes and reads.
    for (int i = 0; i < 4; i++) begin
      a = 32'h3000_0000 | ($urandom_range(64, 1022) * 4);
      d = $urandom;
      access(1'b1, a, 4'hF, d);
      access(1'b0, a, 4'hF, 32'h0);
    end
    idle();
    @(negedge clk);

    // Top word of the window: upper lane of macro word 511.
    access(1'b1, 32'h3000_0FFC, 4'hF, 32'hCAFE_F00D);
    access(1'b0, 32'h3000_0FFC, 4'hF, 32'h0);
    chk("top_const", dat_r, 32'hCAFE_F00D);
    chk("top_addr", addr0, 9'd511);

    // Write with no byte selects leaves memory unchanged.
    access(1'b1, 32'h3000_0008, 4'h0, 32'hFFFF_FFFF);
    access(1'b0, 32'h3000_0008, 4'hF, 32'h0);
    chk("sel0_const", dat_r, 32'hDEAD_BEEF);
    idle();
    @(negedge clk);

    // Cycle abandoned during WAIT: no ack, controller recovers.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_000C; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    idle();
    @(posedge clk); @(negedge clk);
    chk("drop_ack", ack, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("drop_ack2", ack, 1'b0);
    last_rd = 32'h1234_5678;
    access(1'b0, 32'h3000_0008, 4'hF, 32'h0);
    idle();
    @(negedge clk);

`ifndef SRAM_CTRL_ERR_EN
    // Out-of-window access aliases onto word 0.
    access(1'b1, 32'h3000_1000, 4'hF, 32'hA5A5_5A5A);
    access(1'b0, 32'h3000_0000, 4'hF, 32'h0);
    chk("alias_const", dat_r, 32'hA5A5_5A5A);
    idle();
    @(negedge clk);
    chk("err_never", err_seen, 0);
`else
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_1000; sel = 4'hF; dat_w = 32'h0;
    @(posedge clk); @(negedge clk);
    chk("oob_err", err, 1'b1);
    chk("oob_csb", csb, 1'b1);
    chk("oob_ack", ack, 1'b0);
    idle();
    @(posedge clk); @(negedge clk);
    chk("oob_err_clear", err, 1'b0);
`endif

    chk("ack_one_cycle", ack_wide, 0);
    chk("csb_no_overlap", csb_overlap, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
